// File: rtl/lcd_timing_gen_if.sv
// LCD timing bundle: panel-side sync/DE/clock and the fetch-side pixel stream.
// master drives everything (the generator); slave observes (panel/fetch logic).
interface lcd_timing_gen_if #(
  parameter int CNT_W  = 11,
  parameter int ADDR_W = 17
);
  logic              lcd_clk;
  logic              lcd_hsync;
  logic              lcd_vsync;
  logic              lcd_de;
  logic              o_valid;
  logic [CNT_W-1:0]  o_x;
  logic [CNT_W-1:0]  o_y;
  logic [ADDR_W-1:0] addr;
  logic              o_vblank;
  logic              frame_start;
  logic              line_start;

  modport master (
    output lcd_clk, lcd_hsync, lcd_vsync, lcd_de,
    output o_valid, o_x, o_y, addr, o_vblank,
    output frame_start, line_start
  );

  modport slave (
    input lcd_clk, lcd_hsync, lcd_vsync, lcd_de,
    input o_valid, o_x, o_y, addr, o_vblank,
    input frame_start, line_start
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: fetch-side pixel stream leading panel sync/DE by PIPE_DLY.
// Ports: clk, rest_n (async low), en (sync run enable), bus (master modport).
module lcd_timing_gen #(
  parameter int H_ACTIVE    = 480,
  parameter int H_FP        = 2,
  parameter int H_SYNC      = 41,
  parameter int H_BP        = 2,
  parameter int V_ACTIVE    = 272,
  parameter int V_FP        = 2,
  parameter int V_SYNC      = 10,
  parameter int V_BP        = 2,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int PIPE_DLY    = 2,
  parameter int CNT_W       = 11,
  parameter int ADDR_W      = 17
) (
  input  logic clk,
  input  logic rest_n,
  input  logic en,
  lcd_timing_gen_if.master bus
);
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] adr_t;

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HS_END = cnt_t'(H_SYNC);
  localparam cnt_t VS_END = cnt_t'(V_SYNC);
  localparam cnt_t HA_BEG = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t VA_BEG = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t HA_END = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t VA_END = cnt_t'(V_SYNC + V_BP + V_ACTIVE);
  localparam cnt_t SMASK  = cnt_t'((1 << SCALE_SHIFT) - 1);
  localparam adr_t FB_W   = adr_t'(H_ACTIVE >> SCALE_SHIFT);

  cnt_t h_cnt, v_cnt;
  logic hs_act, vs_act, h_act, v_act, act;
  cnt_t x, y;

  always_comb begin
    hs_act = h_cnt < HS_END;
    vs_act = v_cnt < VS_END;
    h_act  = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
    v_act  = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    act    = h_act && v_act;
    x      = h_cnt - HA_BEG;
    y      = v_cnt - VA_BEG;
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  logic valid, vblank, fs, ls, hs_q, vs_q;
  cnt_t ox, oy;
  adr_t addr_q, row_base;

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      valid    <= 1'b0;
      vblank   <= 1'b1;
      fs       <= 1'b0;
      ls       <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ox       <= '0;
      oy       <= '0;
      addr_q   <= '0;
      row_base <= '0;
    end else if (!en) begin
      valid    <= 1'b0;
      vblank   <= 1'b1;
      fs       <= 1'b0;
      ls       <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ox       <= '0;
      oy       <= '0;
      addr_q   <= '0;
      row_base <= '0;
    end else begin
      valid  <= act;
      vblank <= !v_act;
      fs     <= (h_cnt == '0) && (v_cnt == '0);
      ls     <= h_cnt == '0;
      hs_q   <= hs_act;
      vs_q   <= vs_act;
      ox     <= act ? x : '0;
      oy     <= act ? y : '0;
      // Row base advances only on lines that start a new
      // framebuffer row; replicated lines replay it.
      if (!act) begin
        addr_q <= '0;
      end else if (x == '0) begin
        if (y == '0) begin
          addr_q   <= '0;
          row_base <= '0;
        end else if ((y & SMASK) == '0) begin
          addr_q   <= row_base + FB_W;
          row_base <= row_base + FB_W;
        end else begin
          addr_q <= row_base;
        end
      end else if ((x & SMASK) == '0) begin
        addr_q <= addr_q + adr_t'(1);
      end
    end
  end

  logic [2:0] cur, tap;
  assign cur = {hs_q, vs_q, valid};

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign tap = cur;
    end else begin : g_dly
      logic [2:0] sr [PIPE_DLY];
      // Keeps shifting while en is low so the panel drains to idle.
      always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
          for (int i = 0; i < PIPE_DLY; i++) sr[i] <= '0;
        end else begin
          sr[0] <= cur;
          for (int i = 1; i < PIPE_DLY; i++) sr[i] <= sr[i-1];
        end
      end
      assign tap = sr[PIPE_DLY-1];
    end
  endgenerate

  assign bus.lcd_clk     = clk & rest_n;
  assign bus.lcd_hsync   = tap[2] ? HS_POL : ~HS_POL;
  assign bus.lcd_vsync   = tap[1] ? VS_POL : ~VS_POL;
  assign bus.lcd_de      = tap[0];
  assign bus.o_valid     = valid;
  assign bus.o_x         = ox;
  assign bus.o_y         = oy;
  assign bus.addr        = addr_q;
  assign bus.o_vblank    = vblank;
  assign bus.frame_start = fs;
  assign bus.line_start  = ls;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen with a small 12x7 raster.
// A reference model queues expected outputs per clock; a monitor compares them.
module tb_lcd_timing_gen;
  localparam int CW = 11;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rest_n = 1'b0;
  logic en = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lcd_timing_gen_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .SCALE_SHIFT(1), .PIPE_DLY(2),
    .CNT_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rest_n(rest_n),
    .en(en),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [AW-1:0] addr;
    logic          vb;
    logic          fs;
    logic          ls;
    logic          hs;
    logic          vs;
    logic          de;
  } exp_t;

  exp_t q[$];

  // Reference model: direct formulas for position and address.
  initial begin
    int mh, mv, xx, yy;
    logic hact, vact;
    logic m_valid, m_vb, m_fs, m_ls, m_hs, m_vs;
    logic [CW-1:0] m_x, m_y;
    logic [AW-1:0] m_addr;
    logic [2:0] p0, p1;
    exp_t e;
    mh = 0; mv = 0;
    m_valid = 0; m_vb = 1; m_fs = 0; m_ls = 0;
    m_hs = 0; m_vs = 0; m_x = 0; m_y = 0; m_addr = 0;
    p0 = 0; p1 = 0;
    forever begin
      @(posedge clk);
      if (!rest_n) begin
        mh = 0; mv = 0;
        m_valid = 0; m_vb = 1; m_fs = 0; m_ls = 0;
        m_hs = 0; m_vs = 0; m_x = 0; m_y = 0; m_addr = 0;
        p0 = 0; p1 = 0;
      end else begin
        p1 = p0;
        p0 = {m_hs, m_vs, m_valid};
        if (en) begin
          hact = (mh >= 2) && (mh < 10);
          vact = (mv >= 2) && (mv < 6);
          xx = mh - 2;
          yy = mv - 2;
          m_valid = hact && vact;
          m_x = m_valid ? CW'(xx) : '0;
          m_y = m_valid ? CW'(yy) : '0;
          m_addr = m_valid ? AW'((yy / 2) * 4 + (xx / 2)) : '0;
          m_vb = !vact;
          m_fs = (mh == 0) && (mv == 0);
          m_ls = (mh == 0);
          m_hs = (mh < 1);
          m_vs = (mv < 1);
          if (mh == 11) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
          end else begin
            mh++;
          end
        end else begin
          mh = 0; mv = 0;
          m_valid = 0; m_vb = 1; m_fs = 0; m_ls = 0;
          m_hs = 0; m_vs = 0; m_x = 0; m_y = 0; m_addr = 0;
        end
      end
      e.valid = m_valid;
      e.x = m_x;
      e.y = m_y;
      e.addr = m_addr;
      e.vb = m_vb;
      e.fs = m_fs;
      e.ls = m_ls;
      e.hs = p1[2];
      e.vs = p1[1];
      e.de = p1[0];
      q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("o_valid", bus.o_valid, e.valid);
        chk("o_x", bus.o_x, e.x);
        chk("o_y", bus.o_y, e.y);
        chk("addr", bus.addr, e.addr);
        chk("o_vblank", bus.o_vblank, e.vb);
        chk("frame_start", bus.frame_start, e.fs);
        chk("line_start", bus.line_start, e.ls);
        chk("lcd_hsync", bus.lcd_hsync, !e.hs);
        chk("lcd_vsync", bus.lcd_vsync, !e.vs);
        chk("lcd_de", bus.lcd_de, e.de);
      end
    end
  end

  task automatic wait_valid(input int lim);
    bit found;
    found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (bus.o_valid) found = 1;
    end
    if (!found) chk("wait_valid", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, vsl, hsl, fs_a, fs_b, ls_p, ls_l;
    vcnt = 0; vsl = 0; hsl = 0;
    fs_a = -1; fs_b = -1; ls_p = 0; ls_l = 0;

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 chk("lcd_clk_rst", bus.lcd_clk, 0);
    @(negedge clk);
    rest_n = 1;
    @(posedge clk);
    #1 chk("lcd_clk_run", bus.lcd_clk, 1);

    for (int i = 1; i <= 168; i++) begin
      @(negedge clk);
      if (i == 1) chk("fs_first", bus.frame_start, 1);
      if (i <= 84) begin
        if (bus.o_valid) vcnt++;
        if (!bus.lcd_vsync) vsl++;
        if (!bus.lcd_hsync) hsl++;
      end
      if (bus.frame_start) begin
        if (fs_a < 0) fs_a = i;
        else if (fs_b < 0) fs_b = i;
      end
      if (bus.line_start) begin
        ls_p = ls_l;
        ls_l = i;
      end
    end
    chk("valid_cnt", vcnt, 32);
    chk("vs_low", vsl, 12);
    chk("hs_low", hsl, 7);
    chk("fs_period", fs_b - fs_a, 84);
    chk("ls_period", ls_l - ls_p, 12);

    wait_valid(40);
    en = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.o_valid, 0);
      if (i >= 3) chk("stall_de", bus.lcd_de, 0);
    end
    en = 1;
    @(negedge clk);
    chk("fs_resume", bus.frame_start, 1);
    wait_valid(40);
    chk("addr_resume", bus.addr, 0);
    chk("y_resume", bus.o_y, 0);
    repeat (90) @(negedge clk);

    wait_valid(100);
    repeat (2) @(negedge clk);
    chk("de_pre_rst", bus.lcd_de, 1);
    #2 rest_n = 0;
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_x", bus.o_x, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_vblank", bus.o_vblank, 1);
    chk("rst_de", bus.lcd_de, 0);
    chk("rst_hsync", bus.lcd_hsync, 1);
    chk("rst_vsync", bus.lcd_vsync, 1);
    @(posedge clk);
    #1 chk("rst_lcd_clk", bus.lcd_clk, 0);
    repeat (2) @(negedge clk);
    rest_n = 1;
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
